fpu_exp_align_pipe: RTL and testbench

//   Two-stage pipelined exponent comparator / mantissa aligner for the FPU add/sub path.
//   - Compares two operands: exponent first, then mantissa.
//   - Orders them so the "big" operand has magnitude >= the "small" one.
//   - Right-shifts the small mantissa by the exponent difference, producing guard/round/sticky bits.
//   - Sits between operand unpack and the mantissa adder.
//   - Valid/ready handshake on both sides; full throughput.

---
 rtl/fpu_exp_align_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_fpu_exp_align_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_exp_align_pipe.sv
//============================================================================
// Module      : fpu_exp_align_pipe
// Description : Two-stage exponent compare / mantissa align pipeline for the
//               FPU add/sub path, valid/ready on both sides, full throughput.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module fpu_exp_align_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               a_sign,
    input  logic [EXP_W-1:0]   a_exp,
    input  logic [MAN_W-1:0]   a_man,
    input  logic               b_sign,
    input  logic [EXP_W-1:0]   b_exp,
    input  logic [MAN_W-1:0]   b_man,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   out_exp,
    output logic [EXP_W-1:0]   out_diff,
    output logic               out_big_sign,
    output logic [MAN_W+2:0]   out_big_man,
    output logic               out_sml_sign,
    output logic [MAN_W+2:0]   out_sml_man,
    output logic               out_swap,
    output logic               out_eq
);

    localparam int c_ext_w = MAN_W + 3;
    localparam int c_sh_w  = $clog2(c_ext_w);

    // Handshake
    logic w_s2_adv;
    logic w_s1_adv;

    // Stage 1 compare
    logic [EXP_W:0]   w_exp_sub;
    logic             w_b_exp_gt;
    logic             w_exp_eq;
    logic             w_man_eq;
    logic             w_b_man_gt;
    logic             w_in_eq;
    logic             w_in_swap;
    logic [EXP_W-1:0] w_in_diff;

    // Stage 1 registers
    logic             s1_valid_d,    s1_valid_q;
    logic [EXP_W-1:0] s1_diff_d,     s1_diff_q;
    logic             s1_swap_d,     s1_swap_q;
    logic             s1_eq_d,       s1_eq_q;
    logic [EXP_W-1:0] s1_exp_d,      s1_exp_q;
    logic             s1_big_sign_d, s1_big_sign_q;
    logic [MAN_W-1:0] s1_big_man_d,  s1_big_man_q;
    logic             s1_sml_sign_d, s1_sml_sign_q;
    logic [MAN_W-1:0] s1_sml_man_d,  s1_sml_man_q;

    // Stage 2 align
    logic [c_ext_w-1:0] w_sml_ext;
    logic [c_sh_w-1:0]  w_sh_amt;
    logic               w_far;
    logic [c_ext_w-1:0] w_shifted;
    logic [c_ext_w-1:0] w_lost_mask;
    logic               w_sticky;
    logic [c_ext_w-1:0] w_sml_aligned;

    // Stage 2 registers
    logic               out_valid_d,    out_valid_q;
    logic [EXP_W-1:0]   out_exp_d,      out_exp_q;
    logic [EXP_W-1:0]   out_diff_d,     out_diff_q;
    logic               out_big_sign_d, out_big_sign_q;
    logic [c_ext_w-1:0] out_big_man_d,  out_big_man_q;
    logic               out_sml_sign_d, out_sml_sign_q;
    logic [c_ext_w-1:0] out_sml_man_d,  out_sml_man_q;
    logic               out_swap_d,     out_swap_q;
    logic               out_eq_d,       out_eq_q;

    // A stage advances when it is empty or its consumer is taking its content.
    assign w_s2_adv = !out_valid_q || out_ready;
    assign w_s1_adv = !s1_valid_q || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_comb begin
        w_exp_sub  = {1'b0, a_exp} - {1'b0, b_exp};
        w_b_exp_gt = w_exp_sub[EXP_W];
        w_exp_eq   = (a_exp == b_exp);
        w_man_eq   = (a_man == b_man);
        w_b_man_gt = (b_man > a_man);
        w_in_eq    = w_exp_eq && w_man_eq;
        w_in_swap  = !w_in_eq && (w_b_exp_gt || (w_exp_eq && w_b_man_gt));
        w_in_diff  = w_b_exp_gt ? (b_exp - a_exp) : w_exp_sub[EXP_W-1:0];
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_diff_d     = s1_diff_q;
        s1_swap_d     = s1_swap_q;
        s1_eq_d       = s1_eq_q;
        s1_exp_d      = s1_exp_q;
        s1_big_sign_d = s1_big_sign_q;
        s1_big_man_d  = s1_big_man_q;
        s1_sml_sign_d = s1_sml_sign_q;
        s1_sml_man_d  = s1_sml_man_q;
        if (w_s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_diff_d = w_in_diff;
                s1_swap_d = w_in_swap;
                s1_eq_d   = w_in_eq;
                if (w_in_swap) begin
                    s1_exp_d      = b_exp;
                    s1_big_sign_d = b_sign;
                    s1_big_man_d  = b_man;
                    s1_sml_sign_d = a_sign;
                    s1_sml_man_d  = a_man;
                end else begin
                    s1_exp_d      = a_exp;
                    s1_big_sign_d = a_sign;
                    s1_big_man_d  = a_man;
                    s1_sml_sign_d = b_sign;
                    s1_sml_man_d  = b_man;
                end
            end
        end
    end

    // Shifts of the full width or more leave only the sticky bit.
    always_comb begin
        w_sml_ext     = {s1_sml_man_q, 3'b000};
        w_sh_amt      = s1_diff_q[c_sh_w-1:0];
        w_far         = (32'(s1_diff_q) >= 32'(c_ext_w));
        w_shifted     = w_sml_ext >> w_sh_amt;
        w_lost_mask   = ~({c_ext_w{1'b1}} << w_sh_amt);
        w_sticky      = w_far ? (|s1_sml_man_q) : (|(w_sml_ext & w_lost_mask));
        w_sml_aligned = w_far ? '0 : w_shifted;
        w_sml_aligned[0] = w_sml_aligned[0] | w_sticky;
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_exp_d      = out_exp_q;
        out_diff_d     = out_diff_q;
        out_big_sign_d = out_big_sign_q;
        out_big_man_d  = out_big_man_q;
        out_sml_sign_d = out_sml_sign_q;
        out_sml_man_d  = out_sml_man_q;
        out_swap_d     = out_swap_q;
        out_eq_d       = out_eq_q;
        if (w_s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_exp_d      = s1_exp_q;
                out_diff_d     = s1_diff_q;
                out_big_sign_d = s1_big_sign_q;
                out_big_man_d  = {s1_big_man_q, 3'b000};
                out_sml_sign_d = s1_sml_sign_q;
                out_sml_man_d  = w_sml_aligned;
                out_swap_d     = s1_swap_q;
                out_eq_d       = s1_eq_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_diff_q      <= '0;
            s1_swap_q      <= 1'b0;
            s1_eq_q        <= 1'b0;
            s1_exp_q       <= '0;
            s1_big_sign_q  <= 1'b0;
            s1_big_man_q   <= '0;
            s1_sml_sign_q  <= 1'b0;
            s1_sml_man_q   <= '0;
            out_valid_q    <= 1'b0;
            out_exp_q      <= '0;
            out_diff_q     <= '0;
            out_big_sign_q <= 1'b0;
            out_big_man_q  <= '0;
            out_sml_sign_q <= 1'b0;
            out_sml_man_q  <= '0;
            out_swap_q     <= 1'b0;
            out_eq_q       <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_diff_q      <= s1_diff_d;
            s1_swap_q      <= s1_swap_d;
            s1_eq_q        <= s1_eq_d;
            s1_exp_q       <= s1_exp_d;
            s1_big_sign_q  <= s1_big_sign_d;
            s1_big_man_q   <= s1_big_man_d;
            s1_sml_sign_q  <= s1_sml_sign_d;
            s1_sml_man_q   <= s1_sml_man_d;
            out_valid_q    <= out_valid_d;
            out_exp_q      <= out_exp_d;
            out_diff_q     <= out_diff_d;
            out_big_sign_q <= out_big_sign_d;
            out_big_man_q  <= out_big_man_d;
            out_sml_sign_q <= out_sml_sign_d;
            out_sml_man_q  <= out_sml_man_d;
            out_swap_q     <= out_swap_d;
            out_eq_q       <= out_eq_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_exp      = out_exp_q;
    assign out_diff     = out_diff_q;
    assign out_big_sign = out_big_sign_q;
    assign out_big_man  = out_big_man_q;
    assign out_sml_sign = out_sml_sign_q;
    assign out_sml_man  = out_sml_man_q;
    assign out_swap     = out_swap_q;
    assign out_eq       = out_eq_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_exp_align_pipe.sv
//============================================================================
// Module      : tb_fpu_exp_align_pipe
// Description : Self-checking bench for fpu_exp_align_pipe (EXP_W=8, MAN_W=24).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fpu_exp_align_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 24;

    typedef struct packed {
        logic [7:0]  xexp;
        logic [7:0]  diff;
        logic        bsign;
        logic [26:0] bman;
        logic        ssign;
        logic [26:0] sman;
        logic        swap;
        logic        eq;
    } res_t;

    typedef struct {
        logic        a_s;
        logic [7:0]  a_e;
        logic [23:0] a_m;
        logic        b_s;
        logic [7:0]  b_e;
        logic [23:0] b_m;
        res_t        exp_r;
    } vec_t;

    logic             clk, rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [EXP_W-1:0] out_exp, out_diff;
    logic             out_big_sign, out_sml_sign, out_swap, out_eq;
    logic [MAN_W+2:0] out_big_man, out_sml_man;
    res_t             act;

    fpu_exp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .a_exp(a_exp), .a_man(a_man),
        .b_sign(b_sign), .b_exp(b_exp), .b_man(b_man),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_diff(out_diff),
        .out_big_sign(out_big_sign), .out_big_man(out_big_man),
        .out_sml_sign(out_sml_sign), .out_sml_man(out_sml_man),
        .out_swap(out_swap), .out_eq(out_eq)
    );

    assign act = {out_exp, out_diff, out_big_sign, out_big_man,
                  out_sml_sign, out_sml_man, out_swap, out_eq};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[13];

    function automatic vec_t mkv(logic as_, logic [7:0] ae, logic [23:0] am,
                                 logic bs_, logic [7:0] be, logic [23:0] bm,
                                 logic [7:0] xe, logic [7:0] df, logic bsg,
                                 logic [26:0] bmn, logic ssg, logic [26:0] smn,
                                 logic sw, logic eqv);
        vec_t v;
        v.a_s = as_; v.a_e = ae; v.a_m = am;
        v.b_s = bs_; v.b_e = be; v.b_m = bm;
        v.exp_r = {xe, df, bsg, bmn, ssg, smn, sw, eqv};
        return v;
    endfunction

    // Reference: alignment via 64-bit arithmetic, sticky = shift is not lossless.
    function automatic res_t model(vec_t v);
        res_t r;
        bit b_big;
        int d;
        logic [23:0] sm;
        logic [63:0] e, sh;
        b_big  = (v.b_e > v.a_e) || ((v.b_e == v.a_e) && (v.b_m > v.a_m));
        r.eq   = (v.a_e == v.b_e) && (v.a_m == v.b_m);
        r.swap = b_big;
        if (b_big) begin
            r.xexp = v.b_e; d = int'(v.b_e) - int'(v.a_e);
            r.bsign = v.b_s; r.bman = {v.b_m, 3'b000}; r.ssign = v.a_s; sm = v.a_m;
        end else begin
            r.xexp = v.a_e; d = int'(v.a_e) - int'(v.b_e);
            r.bsign = v.a_s; r.bman = {v.a_m, 3'b000}; r.ssign = v.b_s; sm = v.b_m;
        end
        r.diff = 8'(d);
        e = 64'(sm) * 64'd8;
        if (d >= 27) begin
            r.sman = (sm != 0) ? 27'd1 : 27'd0;
        end else begin
            sh = e >> d;
            r.sman = 27'(sh) | {26'd0, ((sh << d) != e)};
        end
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] actual, logic [127:0] expv);
        checks++;
        if (actual !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expv);
        end
    endtask

    task automatic send(input vec_t v, input bit rnd);
        int n = 0;
        bit acc = 1'b0;
        a_sign = v.a_s; a_exp = v.a_e; a_man = v.a_m;
        b_sign = v.b_s; b_exp = v.b_e; b_man = v.b_m;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            if (acc) sb.push_back(v.exp_r);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready never rose in %0d cycles", n);
        end
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (sb.size() > 0 && n < 400) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        chk("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mkv(0, 130, 24'hC00000, 1, 128, 24'h800000, 130, 2,   0, 27'h6000000, 1, 27'h1000000, 0, 0);
        tbl[1]  = mkv(0, 100, 24'h800000, 0, 101, 24'h800000, 101, 1,   0, 27'h4000000, 0, 27'h2000000, 1, 0);
        tbl[2]  = mkv(0, 150, 24'h800000, 1, 120, 24'h800001, 150, 30,  0, 27'h4000000, 1, 27'h0000001, 0, 0);
        tbl[3]  = mkv(0, 150, 24'h800000, 1, 120, 24'h000000, 150, 30,  0, 27'h4000000, 1, 27'h0000000, 0, 0);
        tbl[4]  = mkv(0, 127, 24'h800000, 0, 127, 24'h900000, 127, 0,   0, 27'h4800000, 0, 27'h4000000, 1, 0);
        tbl[5]  = mkv(1, 127, 24'hA00000, 1, 127, 24'hA00000, 127, 0,   1, 27'h5000000, 1, 27'h5000000, 0, 1);
        tbl[6]  = mkv(0, 50,  24'h800001, 1, 53,  24'hFFFFFF, 53,  3,   1, 27'h7FFFFF8, 0, 27'h0800001, 1, 0);
        tbl[7]  = mkv(0, 60,  24'h800001, 0, 56,  24'h800001, 60,  4,   0, 27'h4000008, 0, 27'h0400001, 0, 0);
        tbl[8]  = mkv(0, 200, 24'h800000, 0, 174, 24'h800000, 200, 26,  0, 27'h4000000, 0, 27'h0000001, 0, 0);
        tbl[9]  = mkv(0, 201, 24'h800000, 1, 174, 24'h800000, 201, 27,  0, 27'h4000000, 1, 27'h0000001, 0, 0);
        tbl[10] = mkv(0, 0,   24'h800001, 0, 255, 24'h800000, 255, 255, 0, 27'h4000000, 0, 27'h0000001, 1, 0);
        tbl[11] = mkv(1, 25,  24'hFFFFFF, 0, 0,   24'hFFFFFF, 25,  25,  1, 27'h7FFFFF8, 0, 27'h0000003, 0, 0);
        tbl[12] = mkv(1, 10,  24'h900000, 0, 10,  24'h800000, 10,  0,   1, 27'h4800000, 0, 27'h4000000, 0, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_sign = 0; a_exp = '0; a_man = '0; b_sign = 0; b_exp = '0; b_man = '0;

        // Output scoreboard/hold monitor, sampling on the falling edge.
        fork
            begin : mon
                bit   prev_stall = 1'b0;
                res_t prev_out = '0;
                res_t e;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_stall = 1'b0;
                    end else begin
                        if (prev_stall) begin
                            checks++;
                            if (!out_valid || act !== prev_out) begin
                                errors++;
                                $display("FAIL hold: valid=%0b out=%h required valid=1 out=%h", out_valid, act, prev_out);
                            end
                        end
                        if (out_valid && out_ready) begin
                            checks++;
                            if (sb.size() == 0) begin
                                errors++;
                                $display("FAIL extra_output: got %h with nothing outstanding", act);
                            end else begin
                                e = sb.pop_front();
                                if (act !== e) begin
                                    errors++;
                                    $display("FAIL result: got exp=%0d diff=%0d bs=%0b bm=%h ss=%0b sm=%h swap=%0b eq=%0b required exp=%0d diff=%0d bs=%0b bm=%h ss=%0b sm=%h swap=%0b eq=%0b",
                                             act.xexp, act.diff, act.bsign, act.bman, act.ssign, act.sman, act.swap, act.eq,
                                             e.xexp, e.diff, e.bsign, e.bman, e.ssign, e.sman, e.swap, e.eq);
                                end
                            end
                        end
                        prev_stall = out_valid && !out_ready;
                        prev_out   = act;
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_data", 128'(act), 128'd0);
        rst = 1'b0;

        // Latency with no stall: accept edge, then valid one edge later.
        out_ready = 1'b1;
        send(tbl[0], 1'b0);
        chk("lat_after_accept", 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        chk("lat_two_cycles", 128'(out_valid), 128'd1);
        drain(1'b0);

        for (int i = 1; i < 13; i++) send(tbl[i], 1'b0);
        drain(1'b0);

        // Backpressure: two accepted, third blocked, then released with no gaps.
        out_ready = 1'b0;
        send(tbl[6], 1'b0);
        send(tbl[7], 1'b0);
        a_sign = tbl[8].a_s; a_exp = tbl[8].a_e; a_man = tbl[8].a_m;
        b_sign = tbl[8].b_s; b_exp = tbl[8].b_e; b_man = tbl[8].b_m;
        in_valid = 1'b1;
        #1;
        chk("full_in_ready", 128'(in_ready), 128'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("full_in_ready_held", 128'(in_ready), 128'd0);
        chk("full_out_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        #1;
        chk("full_pass_through", 128'(in_ready), 128'd1);
        sb.push_back(tbl[8].exp_r);
        for (int k = 0; k < 3; k++) begin
            chk("release_no_gap", 128'(out_valid), 128'd1);
            @(posedge clk); #1;
            if (k == 0) in_valid = 1'b0;
        end
        chk("release_all_out", 128'(sb.size()), 128'd0);
        chk("release_empty", 128'(out_valid), 128'd0);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        send(tbl[3], 1'b0);
        send(tbl[4], 1'b0);
        chk("pre_rst_full", 128'(out_valid), 128'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'd0);
        chk("async_rst_ready", 128'(in_ready), 128'd1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(tbl[5], 1'b0);
        chk("post_rst_lat1", 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        chk("post_rst_lat2", 128'(out_valid), 128'd1);
        drain(1'b0);

        // Random operands under random backpressure.
        for (int k = 0; k < 60; k++) begin
            v.a_s = 1'($urandom); v.b_s = 1'($urandom);
            v.a_e = 8'($urandom);
            v.b_e = (k % 2 == 0) ? (v.a_e ^ 8'($urandom_range(0, 31))) : 8'($urandom);
            v.a_m = (k % 11 == 5) ? 24'd0 : {1'b1, 23'($urandom)};
            v.b_m = (k % 7 == 3) ? v.a_m : {1'b1, 23'($urandom)};
            if (k % 9 == 4) v.b_e = v.a_e;
            v.exp_r = model(v);
            send(v, 1'b1);
        end
        drain(1'b1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
